// File: rtl/cflog_write_seq.sv
// Control-flow log writer: accepts src/dest pairs, writes them as two consecutive
// log words, and requests a flush when the log fills or the final pair is written.
module cflog_write_seq #(
  parameter logic [15:0] LOG_SIZE = 16'h0100
) (
  input  logic        clk,
  input  logic        puc,
  input  logic        entry_valid,
  output logic        entry_ready,
  input  logic [15:0] entry_src,
  input  logic [15:0] entry_dest,
  input  logic        entry_final,
  output logic        hw_wen,
  output logic [15:0] log_ptr,
  output logic [15:0] log_data,
  output logic        flush,
  input  logic        flush_ack
);

  typedef enum logic [1:0] {StIdle, StWrSrc, StWrDest, StFlush} state_e;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dest_q, dest_d;
  logic        final_q, final_d;
  logic [15:0] ptr_inc;

  assign ptr_inc = ptr_q + 16'd1;
  assign log_ptr = ptr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    src_d       = src_q;
    dest_d      = dest_q;
    final_d     = final_q;
    entry_ready = 1'b0;
    hw_wen      = 1'b0;
    log_data    = 16'h0000;
    flush       = 1'b0;

    unique case (state_q)
      StIdle: begin
        entry_ready = 1'b1;
        if (entry_valid) begin
          src_d   = entry_src;
          dest_d  = entry_dest;
          final_d = entry_final;
          state_d = StWrSrc;
        end
      end
      StWrSrc: begin
        hw_wen   = 1'b1;
        log_data = src_q;
        ptr_d    = ptr_inc;
        state_d  = StWrDest;
      end
      StWrDest: begin
        hw_wen   = 1'b1;
        log_data = dest_q;
        ptr_d    = ptr_inc;
        // The incremented pointer is kept through FLUSH so the TCB sees the fill level.
        state_d  = ((ptr_inc == LOG_SIZE) || final_q) ? StFlush : StIdle;
      end
      StFlush: begin
        flush = 1'b1;
        if (flush_ack) begin
          ptr_d   = 16'h0000;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset overrides outputs too, so an in-flight write is suppressed in the puc cycle.
    if (puc) begin
      state_d     = StIdle;
      ptr_d       = 16'h0000;
      src_d       = 16'h0000;
      dest_d      = 16'h0000;
      final_d     = 1'b0;
      entry_ready = 1'b1;
      hw_wen      = 1'b0;
      log_data    = 16'h0000;
      flush       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    src_q   <= src_d;
    dest_q  <= dest_d;
    final_q <= final_d;
  end

endmodule

// File: tb/tb_cflog_write_seq.sv
// Directed bench for cflog_write_seq with an 8-word log; expected values are hand-derived.
module tb_cflog_write_seq;

  logic        clk = 1'b0;
  logic        puc;
  logic        entry_valid;
  logic        entry_ready;
  logic [15:0] entry_src;
  logic [15:0] entry_dest;
  logic        entry_final;
  logic        hw_wen;
  logic [15:0] log_ptr;
  logic [15:0] log_data;
  logic        flush;
  logic        flush_ack;

  int checks = 0;
  int errors = 0;

  cflog_write_seq #(.LOG_SIZE(16'h0008)) dut (
    .clk        (clk),
    .puc        (puc),
    .entry_valid(entry_valid),
    .entry_ready(entry_ready),
    .entry_src  (entry_src),
    .entry_dest (entry_dest),
    .entry_final(entry_final),
    .hw_wen     (hw_wen),
    .log_ptr    (log_ptr),
    .log_data   (log_data),
    .flush      (flush),
    .flush_ack  (flush_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller must be in IDLE; returns with the pair fully written.
  task automatic send_pair(input logic [15:0] s, input logic [15:0] d, input logic f);
    entry_valid = 1'b1;
    entry_src   = s;
    entry_dest  = d;
    entry_final = f;
    tick();
    entry_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    puc         = 1'b1;
    entry_valid = 1'b0;
    entry_src   = 16'h0000;
    entry_dest  = 16'h0000;
    entry_final = 1'b0;
    flush_ack   = 1'b0;
    tick();
    tick();
    puc = 1'b0;
    check("rst_ready", {15'd0, entry_ready}, 16'd1);
    check("rst_wen",   {15'd0, hw_wen},      16'd0);
    check("rst_flush", {15'd0, flush},       16'd0);
    check("rst_ptr",   log_ptr,              16'd0);
    check("rst_data",  log_data,             16'd0);

    // Single pair with per-cycle latency checks; inputs scrambled after accept.
    entry_valid = 1'b1;
    entry_src   = 16'hE100;
    entry_dest  = 16'hE200;
    entry_final = 1'b0;
    tick();
    entry_valid = 1'b0;
    entry_src   = 16'hDEAD;
    entry_dest  = 16'hBEEF;
    entry_final = 1'b1;
    check("src_wen",   {15'd0, hw_wen},      16'd1);
    check("src_ptr",   log_ptr,              16'd0);
    check("src_data",  log_data,             16'hE100);
    check("src_ready", {15'd0, entry_ready}, 16'd0);
    tick();
    check("dst_wen",   {15'd0, hw_wen},      16'd1);
    check("dst_ptr",   log_ptr,              16'd1);
    check("dst_data",  log_data,             16'hE200);
    tick();
    check("n3_ready",  {15'd0, entry_ready}, 16'd1);
    check("n3_ptr",    log_ptr,              16'd2);
    check("n3_flush",  {15'd0, flush},       16'd0);
    check("n3_wen",    {15'd0, hw_wen},      16'd0);
    check("n3_data",   log_data,             16'd0);

    send_pair(16'h1002, 16'h2003, 1'b0);
    send_pair(16'h1004, 16'h2005, 1'b0);
    check("pre_ack_ptr", log_ptr, 16'd6);

    // Spurious ack in IDLE.
    flush_ack = 1'b1;
    tick();
    tick();
    flush_ack = 1'b0;
    check("spur_ptr",   log_ptr,              16'd6);
    check("spur_ready", {15'd0, entry_ready}, 16'd1);
    check("spur_flush", {15'd0, flush},       16'd0);

    // Pair filling the log, then backpressure during FLUSH.
    send_pair(16'h1006, 16'h2007, 1'b0);
    check("fill_flush", {15'd0, flush},       16'd1);
    check("fill_ptr",   log_ptr,              16'd8);
    check("fill_ready", {15'd0, entry_ready}, 16'd0);
    entry_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      entry_src  = 16'h3000 + 16'(i);
      entry_dest = 16'h4000 + 16'(i);
      tick();
      check("bp_wen",   {15'd0, hw_wen}, 16'd0);
      check("bp_flush", {15'd0, flush},  16'd1);
    end
    check("bp_ptr", log_ptr, 16'd8);
    entry_src   = 16'hA5A5;
    entry_dest  = 16'h5A5A;
    entry_final = 1'b1;
    flush_ack   = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("ack_ptr",   log_ptr,              16'd0);
    check("ack_ready", {15'd0, entry_ready}, 16'd1);
    check("ack_flush", {15'd0, flush},       16'd0);

    // First accept after flush takes the data present then; final=1 at ptr 0.
    tick();
    entry_valid = 1'b0;
    check("bp_src_data", log_data, 16'hA5A5);
    check("bp_src_ptr",  log_ptr,  16'd0);
    tick();
    check("bp_dst_data", log_data, 16'h5A5A);
    check("bp_dst_ptr",  log_ptr,  16'd1);
    tick();
    check("fin_flush", {15'd0, flush}, 16'd1);
    check("fin_ptr",   log_ptr,        16'd2);
    tick();
    tick();
    tick();
    check("fin_hold", {15'd0, flush}, 16'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("fin_ack_ptr",   log_ptr,              16'd0);
    check("fin_ack_ready", {15'd0, entry_ready}, 16'd1);

    // Reset in WR_DEST suppresses the dest write.
    entry_valid = 1'b1;
    entry_src   = 16'h7777;
    entry_dest  = 16'h8888;
    entry_final = 1'b0;
    tick();
    entry_valid = 1'b0;
    tick();
    puc = 1'b1;
    #1;
    check("puc_wen",   {15'd0, hw_wen},      16'd0);
    check("puc_data",  log_data,             16'd0);
    check("puc_ready", {15'd0, entry_ready}, 16'd1);
    flush_ack   = 1'b1;
    entry_valid = 1'b1;
    tick();
    puc         = 1'b0;
    flush_ack   = 1'b0;
    entry_valid = 1'b0;
    check("post_puc_ptr",   log_ptr,              16'd0);
    check("post_puc_wen",   {15'd0, hw_wen},      16'd0);
    check("post_puc_flush", {15'd0, flush},       16'd0);
    check("post_puc_ready", {15'd0, entry_ready}, 16'd1);

    // Full log and final together give one FLUSH.
    send_pair(16'h0100, 16'h0200, 1'b0);
    send_pair(16'h0101, 16'h0201, 1'b0);
    send_pair(16'h0102, 16'h0202, 1'b0);
    send_pair(16'h0103, 16'h0203, 1'b1);
    check("both_flush", {15'd0, flush}, 16'd1);
    check("both_ptr",   log_ptr,        16'd8);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("both_ack_flush", {15'd0, flush}, 16'd0);
    tick();
    check("both_single", {15'd0, flush},       16'd0);
    check("both_ready",  {15'd0, entry_ready}, 16'd1);
    check("both_ptr0",   log_ptr,              16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
